// File: rtl/coherent_averager_pkg.sv
// Shared types and helpers for the coherent averager.
// Accumulator width and output saturation live here.
package coherent_averager_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WAIT_TRIG,
    DUMP
  } state_t;

  function automatic int acc_w(input int dw, input int max_l2);
    return dw + max_l2;
  endfunction

  // Clamp to a dw-bit signed range, returned sign-extended to 32 bits
  function automatic logic [31:0] sat_trunc(
    input logic signed [63:0] v,
    input int                 dw
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi[31:0];
    if (v < lo) return lo[31:0];
    return v[31:0];
  endfunction

endpackage

// File: rtl/coherent_averager_acc_ram.sv
// Accumulator store: one write port, one registered read port.
// Contents are not reset; the first pass overwrites every index.
module avg_acc_ram #(
  parameter int DEPTH = 4096,
  parameter int WIDTH = 26,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/coherent_averager.sv
// Triggered coherent averager: sums 2^L records of N samples,
// then streams the floored per-index mean with backpressure.
module coherent_averager
  import coherent_averager_pkg::*;
#(
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_SAMPLES  = 4096,
  parameter int MAX_LOG2_AVG = 10
) (
  input  logic                               s00_axis_aclk,
  input  logic                               s00_axis_aresetn,
  input  logic [31:0]                        s00_axis_tdata,
  input  logic                               s00_axis_tvalid,
  output logic                               s00_axis_tready,
  input  logic                               trigger_in,
  input  logic [$clog2(MAX_SAMPLES):0]       num_samples,
  input  logic [$clog2(MAX_LOG2_AVG+1)-1:0]  log2_avg,
  output logic [31:0]                        m00_axis_tdata,
  output logic                               m00_axis_tvalid,
  input  logic                               m00_axis_tready,
  output logic                               m00_axis_tlast,
  output logic [3:0]                         m00_axis_tstrb,
  output logic                               busy,
  output logic [15:0]                        missed_trig,
  output logic [15:0]                        dropped_samp
);

  localparam int AW    = $clog2(MAX_SAMPLES);
  localparam int NW    = AW + 1;
  localparam int LW    = $clog2(MAX_LOG2_AVG + 1);
  localparam int PW    = MAX_LOG2_AVG;
  localparam int ACC_W = acc_w(DATA_WIDTH, MAX_LOG2_AVG);

  logic clk;
  logic rst_n;
  assign clk   = s00_axis_aclk;
  assign rst_n = s00_axis_aresetn;

  state_t                state_q, state_d;
  logic [NW-1:0]         n_q, n_d;
  logic [LW-1:0]         l_q, l_d;
  logic [AW-1:0]         idx_q, idx_d;
  logic [PW-1:0]         pass_q, pass_d;
  logic                  wv_q, wv_d;
  logic                  wclr_q, wclr_d;
  logic [AW-1:0]         waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wsamp_q, wsamp_d;
  logic [NW-1:0]         dptr_q, dptr_d;
  logic                  f_q, f_d;
  logic [AW-1:0]         faddr_q, faddr_d;
  logic                  ov_q, ov_d;
  logic [31:0]           od_q, od_d;
  logic                  ol_q, ol_d;
  logic [15:0]           miss_q, miss_d;
  logic [15:0]           drop_q, drop_d;

  logic [AW-1:0]         rd_addr;
  logic [ACC_W-1:0]      ram_rd;
  logic [ACC_W-1:0]      samp_ext;
  logic [ACC_W-1:0]      wdata;
  logic [AW-1:0]         last_idx;
  logic [PW-1:0]         pass_last;
  logic                  out_free;
  logic                  issue;
  logic signed [63:0]    acc_ext;
  logic [31:0]           mean;
  logic                  unused_tdata;

  assign unused_tdata = ^s00_axis_tdata[31:DATA_WIDTH];

  assign samp_ext  = {{(ACC_W-DATA_WIDTH){wsamp_q[DATA_WIDTH-1]}},
                      wsamp_q};
  assign wdata     = wclr_q ? samp_ext : ram_rd + samp_ext;
  assign last_idx  = AW'(n_q - NW'(1));
  assign pass_last = ~({PW{1'b1}} << l_q);
  assign acc_ext   = {{(64-ACC_W){ram_rd[ACC_W-1]}}, ram_rd};
  assign mean      = sat_trunc(acc_ext >>> l_q, DATA_WIDTH);
  assign out_free  = !ov_q || m00_axis_tready;

  avg_acc_ram #(
    .DEPTH (MAX_SAMPLES),
    .WIDTH (ACC_W),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (wv_q),
    .waddr (waddr_q),
    .wdata (wdata),
    .raddr (rd_addr),
    .rdata (ram_rd)
  );

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    l_d     = l_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    wv_d    = 1'b0;
    wclr_d  = wclr_q;
    waddr_d = waddr_q;
    wsamp_d = wsamp_q;
    dptr_d  = '0;
    f_d     = 1'b0;
    faddr_d = faddr_q;
    ov_d    = ov_q;
    od_d    = od_q;
    ol_d    = ol_q;
    miss_d  = miss_q;
    drop_d  = drop_q;
    rd_addr = idx_q;
    issue   = 1'b0;

    if (trigger_in && (state_q == COLLECT || state_q == DUMP)
        && miss_q != 16'hFFFF)
      miss_d = miss_q + 16'd1;
    if (s00_axis_tvalid && state_q == DUMP && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
    if (ov_q && m00_axis_tready) begin
      ov_d = 1'b0;
      ol_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (trigger_in) begin
          state_d = COLLECT;
          n_d     = num_samples;
          l_d     = log2_avg;
          idx_d   = '0;
          pass_d  = '0;
        end
      end
      WAIT_TRIG: begin
        if (trigger_in) state_d = COLLECT;
      end
      COLLECT: begin
        if (s00_axis_tvalid) begin
          wv_d    = 1'b1;
          wclr_d  = (pass_q == '0);
          waddr_d = idx_q;
          wsamp_d = s00_axis_tdata[DATA_WIDTH-1:0];
          if (idx_q == last_idx) begin
            idx_d = '0;
            if (pass_q == pass_last) begin
              state_d = DUMP;
            end else begin
              pass_d  = pass_q + PW'(1);
              state_d = WAIT_TRIG;
            end
          end else begin
            idx_d = idx_q + AW'(1);
          end
        end
      end
      DUMP: begin
        // A stalled fetch re-reads its address so the RAM output stays live
        issue   = (dptr_q < n_q) && (!f_q || out_free);
        rd_addr = issue ? dptr_q[AW-1:0] : faddr_q;
        dptr_d  = dptr_q + {{(NW-1){1'b0}}, issue};
        f_d     = issue || (f_q && !out_free);
        if (issue) faddr_d = dptr_q[AW-1:0];
        if (f_q && out_free) begin
          ov_d = 1'b1;
          od_d = mean;
          ol_d = (faddr_q == last_idx);
        end
        if (ov_q && m00_axis_tready && ol_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      n_q     <= '0;
      l_q     <= '0;
      idx_q   <= '0;
      pass_q  <= '0;
      wv_q    <= 1'b0;
      wclr_q  <= 1'b0;
      waddr_q <= '0;
      wsamp_q <= '0;
      dptr_q  <= '0;
      f_q     <= 1'b0;
      faddr_q <= '0;
      ov_q    <= 1'b0;
      od_q    <= '0;
      ol_q    <= 1'b0;
      miss_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      l_q     <= l_d;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      wv_q    <= wv_d;
      wclr_q  <= wclr_d;
      waddr_q <= waddr_d;
      wsamp_q <= wsamp_d;
      dptr_q  <= dptr_d;
      f_q     <= f_d;
      faddr_q <= faddr_d;
      ov_q    <= ov_d;
      od_q    <= od_d;
      ol_q    <= ol_d;
      miss_q  <= miss_d;
      drop_q  <= drop_d;
    end
  end

  assign s00_axis_tready = 1'b1;
  assign m00_axis_tdata  = od_q;
  assign m00_axis_tvalid = ov_q;
  assign m00_axis_tlast  = ol_q;
  assign m00_axis_tstrb  = 4'hF;
  assign busy            = (state_q != IDLE);
  assign missed_trig     = miss_q;
  assign dropped_samp    = drop_q;

endmodule

// File: tb/tb_coherent_averager.sv
// Bench for coherent_averager: table of frame configs feeding a
// scoreboard, plus hand sequences for trigger, backpressure and reset.
module tb_coherent_averager;

  logic        clk;
  logic        rst_n;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic        trig;
  logic [12:0] num;
  logic [3:0]  l2;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_last;
  logic [3:0]  m_strb;
  logic        busy;
  logic [15:0] missed;
  logic [15:0] dropped;

  coherent_averager dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rst_n),
    .s00_axis_tdata   (s_data),
    .s00_axis_tvalid  (s_valid),
    .s00_axis_tready  (s_ready),
    .trigger_in       (trig),
    .num_samples      (num),
    .log2_avg         (l2),
    .m00_axis_tdata   (m_data),
    .m00_axis_tvalid  (m_valid),
    .m00_axis_tready  (m_ready),
    .m00_axis_tlast   (m_last),
    .m00_axis_tstrb   (m_strb),
    .busy             (busy),
    .missed_trig      (missed),
    .dropped_samp     (dropped)
  );

  typedef struct {
    logic [31:0] d;
    logic        l;
  } exp_t;

  typedef struct {
    int n;
    int l;
    int base;
    int step;
    int rstep;
    int mode;
    bit gaps;
  } row_t;

  exp_t        q[$];
  row_t        tbl[7];
  int          rec[32][64];
  int          nvec;
  int          nerr;
  int          cyc;
  int          mode;
  logic        hold_v;
  logic [31:0] hold_d;
  logic        hold_l;
  logic        v_neg;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(int md, int c);
    int ph = c % 16;
    case (md)
      0: return 1'b1;
      1: return (c % 2 == 0);
      2: return (ph < 6) ? (c % 2 == 0) : (ph >= 11);
      default: return 1'b0;
    endcase
  endfunction

  task automatic sample();
    exp_t e;
    if (!rst_n) begin
      hold_v = 1'b0;
      return;
    end
    if (hold_v) begin
      chk("hold_valid", {31'd0, m_valid}, 32'd1);
      chk("hold_data", m_data, hold_d);
      chk("hold_last", {31'd0, m_last}, {31'd0, hold_l});
    end
    hold_v = m_valid && !m_ready;
    hold_d = m_data;
    hold_l = m_last;
    v_neg  = m_valid;
    if (m_valid && m_ready) begin
      if (q.size() == 0) begin
        nvec++;
        nerr++;
        $display("FAIL unexpected_beat: got data %h with none expected",
                 m_data);
      end else begin
        e = q.pop_front();
        chk("beat_data", m_data, e.d);
        chk("beat_last", {31'd0, m_last}, {31'd0, e.l});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
    m_ready = rdy(mode, cyc);
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic gen(int base, int step, int rstep, int n, int l);
    logic signed [15:0] t;
    for (int r = 0; r < (1 << l); r++)
      for (int i = 0; i < n; i++) begin
        t = 16'(base + i * step + r * rstep);
        rec[r][i] = int'(t);
      end
  endtask

  task automatic push_exp(int n, int l);
    exp_t e;
    int   sum;
    int   m;
    for (int i = 0; i < n; i++) begin
      sum = 0;
      for (int r = 0; r < (1 << l); r++) sum += rec[r][i];
      m = sum >>> l;
      if (m > 32767) m = 32767;
      if (m < -32768) m = -32768;
      e.d = 32'(m);
      e.l = (i == n - 1);
      q.push_back(e);
    end
  endtask

  task automatic push_lit(logic [31:0] d, logic l);
    exp_t e;
    e.d = d;
    e.l = l;
    q.push_back(e);
  endtask

  task automatic send_rec(int r, int n, bit gaps);
    logic [15:0] t;
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) begin
        s_valid = 1'b0;
        tick();
      end
      t       = 16'(rec[r][i]);
      s_valid = 1'b1;
      s_data  = {16'hA5A5, t};
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic run_frame(int n, int l, bit gaps);
    num = 13'(n);
    l2  = 4'(l);
    pulse_trig();
    num = 13'd3;
    l2  = 4'd7;
    for (int r = 0; r < (1 << l); r++) begin
      if (r > 0) pulse_trig();
      send_rec(r, n, gaps);
    end
  endtask

  task automatic wait_done(string nm);
    int c = 0;
    while ((busy || q.size() != 0) && c < 6000) begin
      tick();
      c++;
    end
    nvec++;
    if (c >= 6000) begin
      nerr++;
      $display("FAIL %s timeout: busy=%0d pending=%0d, required idle",
               nm, busy, q.size());
      q.delete();
    end
  endtask

  initial begin
    logic [15:0] t;
    nvec    = 0;
    nerr    = 0;
    cyc     = 0;
    mode    = 0;
    hold_v  = 1'b0;
    v_neg   = 1'b0;
    rst_n   = 1'b0;
    s_data  = '0;
    s_valid = 1'b0;
    trig    = 1'b0;
    num     = 13'd8;
    l2      = 4'd0;
    m_ready = 1'b1;

    tbl[0] = '{8, 2, 0, 1, 0, 0, 1'b0};
    tbl[1] = '{16, 3, -100, 37, -13, 0, 1'b1};
    tbl[2] = '{2, 0, 32767, 1, 0, 0, 1'b0};
    tbl[3] = '{33, 4, -20000, 1234, 999, 1, 1'b0};
    tbl[4] = '{10, 1, 5, -3, 1, 2, 1'b0};
    tbl[5] = '{64, 5, 30000, -977, 17, 2, 1'b1};
    tbl[6] = '{3, 2, -32768, 0, 0, 0, 1'b0};

    tick();
    tick();
    chk("rst_tvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_tlast", {31'd0, m_last}, 32'd0);
    chk("rst_tdata", m_data, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_missed", {16'd0, missed}, 32'd0);
    chk("rst_dropped", {16'd0, dropped}, 32'd0);
    chk("tready_const", {31'd0, s_ready}, 32'd1);
    chk("tstrb_const", {28'd0, m_strb}, 32'hF);
    rst_n = 1'b1;
    tick();

    for (int k = 0; k < 7; k++) begin
      mode = tbl[k].mode;
      gen(tbl[k].base, tbl[k].step, tbl[k].rstep, tbl[k].n, tbl[k].l);
      push_exp(tbl[k].n, tbl[k].l);
      run_frame(tbl[k].n, tbl[k].l, tbl[k].gaps);
      tick();
      tick();
      tick();
      chk("first_valid_latency", {31'd0, v_neg}, 32'd1);
      wait_done("table_frame");
      chk("table_idle", {31'd0, busy}, 32'd0);
    end
    mode = 0;

    // floor of -1.5 is -2
    for (int i = 0; i < 4; i++) begin
      rec[0][i] = -3;
      rec[1][i] = 0;
      push_lit(32'hFFFF_FFFE, (i == 3));
    end
    run_frame(4, 1, 1'b0);
    wait_done("floor_frame");

    rec[0][0] = 32767;
    rec[0][1] = -32768;
    rec[0][2] = 1;
    rec[0][3] = -1;
    push_lit(32'h0000_7FFF, 1'b0);
    push_lit(32'hFFFF_8000, 1'b0);
    push_lit(32'h0000_0001, 1'b0);
    push_lit(32'hFFFF_FFFF, 1'b1);
    run_frame(4, 0, 1'b0);
    wait_done("l0_frame1");
    for (int i = 0; i < 4; i++) begin
      rec[0][i] = 10 * (i + 1);
      push_lit(32'(10 * (i + 1)), (i == 3));
    end
    run_frame(4, 0, 1'b0);
    wait_done("l0_frame2");

    gen(7, -5, 100, 6, 1);
    push_exp(6, 1);
    num = 13'd6;
    l2  = 4'd1;
    pulse_trig();
    for (int i = 0; i < 6; i++) begin
      t       = 16'(rec[0][i]);
      s_valid = 1'b1;
      s_data  = {16'h0000, t};
      trig    = (i == 3);
      tick();
    end
    s_valid = 1'b0;
    trig    = 1'b0;
    mode    = 3;
    pulse_trig();
    send_rec(1, 6, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'h0000_1234;
    tick();
    tick();
    tick();
    s_valid = 1'b0;
    pulse_trig();
    tick();
    chk("missed_trig", {16'd0, missed}, 32'd2);
    chk("dropped_samp", {16'd0, dropped}, 32'd3);
    chk("busy_in_dump", {31'd0, busy}, 32'd1);
    mode = 0;
    wait_done("trig_frame");
    chk("dropped_final", {16'd0, dropped}, 32'd3);
    chk("missed_final", {16'd0, missed}, 32'd2);

    gen(-500, 211, 73, 8, 1);
    push_exp(8, 1);
    mode = 3;
    run_frame(8, 1, 1'b0);
    tick();
    tick();
    tick();
    tick();
    chk("dump_valid_pre_rst", {31'd0, m_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_tvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_mid_tlast", {31'd0, m_last}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_tdata", m_data, 32'd0);
    chk("rst_mid_missed", {16'd0, missed}, 32'd0);
    q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    mode  = 0;
    tick();
    gen(1200, -333, -41, 8, 1);
    push_exp(8, 1);
    run_frame(8, 1, 1'b0);
    wait_done("post_reset_frame");
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
